// File: rtl/quad_encoder_counter_if.sv
// Encoder-side bundle: synchronized A/B lines and control strobes going in,
// position/step/direction/error status coming back out.
interface quad_encoder_counter_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 enc_a;
    logic                 enc_b;
    logic                 clear;
    logic                 err_clr;
    logic [CNT_WIDTH-1:0] count;   // two's complement position
    logic                 step;
    logic                 dir;
    logic                 err;

    modport master (
        output enc_a, enc_b, clear, err_clr,
        input  count, step, dir, err
    );

    modport slave (
        input  enc_a, enc_b, clear, err_clr,
        output count, step, dir, err
    );
endinterface

// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: per-channel glitch filter, x4 decode into a
// wrapping signed position, one-cycle step pulse with direction, and a sticky
// flag for transitions where both filtered channels move at once.
module quad_encoder_counter #(
    parameter int CNT_WIDTH = 16,
    parameter int FILTER    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    quad_encoder_counter_if.slave  bus
);
    localparam int             FW   = $clog2(FILTER + 1);
    localparam logic [FW-1:0]  LAST = FW'(FILTER - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t               state, state_nxt;
    logic                 load;
    logic                 run;
    logic [FW-1:0]        init_cnt;

    logic [1:0]           raw;      // {a, b}
    logic [1:0]           filt;     // {a_f, b_f}
    logic [1:0]           prev;
    logic                 fwd, rev, ill;

    logic [CNT_WIDTH-1:0] count_q;
    logic                 step_q, dir_q, err_q;

    assign raw = {bus.enc_a, bus.enc_b};
    assign run = (state == RUN);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= state_nxt;
    end

    // FSM next state: INIT waits FILTER clocks, then snapshots the inputs once
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            INIT: begin
                if (init_cnt == LAST) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    // Settling counter for INIT; parks once the snapshot edge is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   init_cnt <= '0;
        else if (state == INIT && init_cnt != LAST) init_cnt <= init_cnt + FW'(1);
    end

    // Per-channel filter: a level must differ from the filtered value for
    // FILTER consecutive samples before it is accepted.
    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic          f_q;
        logic [FW-1:0] f_cnt;

        // Consecutive-difference counter and filtered level for one channel
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                f_q   <= 1'b0;
                f_cnt <= '0;
            end else if (load) begin
                f_q   <= raw[i];
                f_cnt <= '0;
            end else if (run) begin
                if (raw[i] != f_q) begin
                    if (f_cnt == LAST) begin
                        f_q   <= raw[i];
                        f_cnt <= '0;
                    end else begin
                        f_cnt <= f_cnt + FW'(1);
                    end
                end else begin
                    f_cnt <= '0;
                end
            end
        end

        assign filt[i] = f_q;
    end

    // Transition classifier on {prev, cur}; only meaningful in RUN
    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        ill = 1'b0;
        case ({prev, filt})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = run;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev = run;
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: ill = run;
            default: ;
        endcase
    end

    // Decode outputs: clear beats a step for count, error set beats err_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= 2'b00;
            count_q <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (load)     prev <= raw;
            else if (run) prev <= filt;

            step_q <= fwd | rev;

            if (fwd)      dir_q <= 1'b1;
            else if (rev) dir_q <= 1'b0;

            if (bus.clear) count_q <= '0;
            else if (fwd)  count_q <= count_q + CNT_WIDTH'(1);
            else if (rev)  count_q <= count_q - CNT_WIDTH'(1);

            if (ill)              err_q <= 1'b1;
            else if (bus.err_clr) err_q <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.step  = step_q;
    assign bus.dir   = dir_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_quad_encoder_counter.sv
// Directed and randomized bench for quad_encoder_counter against a behavioural
// model: filter = "last FILTER samples agree and differ", decode = position
// index difference modulo 4.
module tb_quad_encoder_counter;
    localparam int CW   = 4;
    localparam int FILT = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    quad_encoder_counter_if #(.CNT_WIDTH(CW)) bus ();

    quad_encoder_counter #(.CNT_WIDTH(CW), .FILTER(FILT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    bit          m_run;
    int          m_init_n;
    bit          m_af, m_bf;
    int          m_prev_idx;
    logic [CW-1:0] m_count;
    bit          m_step, m_dir, m_err;
    bit          ha[$], hb[$];

    // Position index along the forward cycle 00 -> 10 -> 11 -> 01
    function automatic int gidx(bit a, bit b);
        case ({a, b})
            2'b00: return 0;
            2'b10: return 1;
            2'b11: return 2;
            default: return 3;
        endcase
    endfunction

    // True when the last FILT samples all agree and differ from f
    function automatic bit settled(bit h[$], bit f);
        if (h.size() < FILT) return 1'b0;
        for (int k = 0; k < FILT; k++) if (h[k] != h[0]) return 1'b0;
        return h[0] != f;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_run = 0; m_init_n = 0; m_af = 0; m_bf = 0; m_prev_idx = 0;
            m_count = '0; m_step = 0; m_dir = 0; m_err = 0;
            ha.delete(); hb.delete();
        end else if (!m_run) begin
            m_step = 0;
            if (bus.clear) m_count = '0;
            m_init_n++;
            if (m_init_n == FILT) begin
                m_af = bus.enc_a; m_bf = bus.enc_b;
                m_prev_idx = gidx(m_af, m_bf);
                m_run = 1;
            end
        end else begin
            int d;
            d = (gidx(m_af, m_bf) - m_prev_idx + 4) % 4;
            m_step = (d == 1) || (d == 3);
            if (d == 1) begin m_dir = 1; m_count = m_count + 1'b1; end
            if (d == 3) begin m_dir = 0; m_count = m_count - 1'b1; end
            if (bus.clear) m_count = '0;
            if (d == 2) m_err = 1;
            else if (bus.err_clr) m_err = 0;
            m_prev_idx = gidx(m_af, m_bf);
            ha.push_back(bus.enc_a); if (ha.size() > FILT) void'(ha.pop_front());
            hb.push_back(bus.enc_b); if (hb.size() > FILT) void'(hb.pop_front());
            if (settled(ha, m_af)) m_af = ha[0];
            if (settled(hb, m_bf)) m_bf = hb[0];
        end
    end

    // ---------------- helpers ----------------
    int pos;   // index of the encoder state being driven

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string ctx);
        chk({ctx, ".count"}, 32'(bus.count), 32'(m_count));
        chk({ctx, ".step"},  32'(bus.step),  32'(m_step));
        chk({ctx, ".dir"},   32'(bus.dir),   32'(m_dir));
        chk({ctx, ".err"},   32'(bus.err),   32'(m_err));
    endtask

    task automatic tick(input string ctx);
        @(posedge clk); #1;
        chk_model(ctx);
    endtask

    task automatic drive_pos(input int p);
        pos = p % 4;
        case (pos)
            0: begin bus.enc_a = 1'b0; bus.enc_b = 1'b0; end
            1: begin bus.enc_a = 1'b1; bus.enc_b = 1'b0; end
            2: begin bus.enc_a = 1'b1; bus.enc_b = 1'b1; end
            default: begin bus.enc_a = 1'b0; bus.enc_b = 1'b1; end
        endcase
    endtask

    task automatic move(input int delta, input int hold, input string ctx);
        drive_pos(pos + delta + 4);
        for (int k = 0; k < hold; k++) tick(ctx);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        rst = 1'b1;
        bus.clear = 1'b0; bus.err_clr = 1'b0;
        drive_pos(2);                         // enc_a=1, enc_b=1
        #12;
        chk("reset.count", 32'(bus.count), 32'h0);
        chk("reset.step",  32'(bus.step),  32'h0);
        chk("reset.dir",   32'(bus.dir),   32'h0);
        chk("reset.err",   32'(bus.err),   32'h0);
        @(posedge clk); #1; rst = 1'b0;

        // Power-up position 11 is absorbed, never counted
        for (int k = 0; k < 10; k++) tick("init");
        chk("init.count", 32'(bus.count), 32'h0);
        chk("init.err",   32'(bus.err),   32'h0);

        // 8 forward edges; each must decode exactly FILT+1 clocks after the change
        for (int e = 0; e < 8; e++) begin
            lat = 0;
            drive_pos(pos + 1);
            for (int k = 1; k <= 6; k++) begin
                tick("fwd8");
                if (bus.step && lat == 0) lat = k;
            end
            chk("fwd8.latency", 32'(lat), 32'(FILT + 1));
        end
        chk("fwd8.count", 32'(bus.count), 32'h8);
        chk("fwd8.dir",   32'(bus.dir),   32'h1);

        // 3 reverse edges, then a short glitch on A that must be discarded
        for (int e = 0; e < 3; e++) move(-1, 6, "rev3");
        chk("rev3.count", 32'(bus.count), 32'h5);
        chk("rev3.dir",   32'(bus.dir),   32'h0);
        bus.enc_a = ~bus.enc_a;
        for (int k = 0; k < 3; k++) tick("glitch");
        bus.enc_a = ~bus.enc_a;
        for (int k = 0; k < 8; k++) tick("glitch");
        chk("glitch.count", 32'(bus.count), 32'h5);

        // Wrap in both directions at 4 bits
        move(1, 6, "wrap"); move(1, 6, "wrap");
        chk("wrap.seven", 32'(bus.count), 32'h7);
        move(1, 6, "wrap");
        chk("wrap.maxpos", 32'(bus.count), 32'h8);
        bus.clear = 1'b1; tick("clear"); bus.clear = 1'b0;
        chk("clear.count", 32'(bus.count), 32'h0);
        move(-1, 6, "wrap");
        chk("wrap.neg", 32'(bus.count), 32'hF);

        // Illegal jumps and err priority
        while (pos != 0) move(1, 6, "to00");
        move(2, 6, "ill00_11");
        chk("ill.err", 32'(bus.err), 32'h1);
        bus.err_clr = 1'b1; tick("errclr"); bus.err_clr = 1'b0;
        chk("errclr.err", 32'(bus.err), 32'h0);
        drive_pos(pos + 2);                   // 11 -> 00
        for (int k = 0; k < FILT; k++) tick("ill11_00");
        bus.err_clr = 1'b1; tick("setwins"); bus.err_clr = 1'b0;
        chk("setwins.err", 32'(bus.err), 32'h1);
        tick("setwins");

        // Clear coincident with a decoded forward step
        bus.clear = 1'b1; tick("clr"); bus.clear = 1'b0;
        for (int e = 0; e < 12; e++) move(1, 5, "to12");
        chk("to12.count", 32'(bus.count), 32'hC);
        drive_pos(pos + 1);
        for (int k = 0; k < FILT; k++) tick("clrstep");
        bus.clear = 1'b1; tick("clrstep"); bus.clear = 1'b0;
        chk("clrstep.count", 32'(bus.count), 32'h0);
        chk("clrstep.step",  32'(bus.step),  32'h1);
        chk("clrstep.dir",   32'(bus.dir),   32'h1);
        tick("clrstep");

        // Asynchronous reset mid-sequence
        drive_pos(pos + 1);
        tick("midrst"); tick("midrst");
        chk("midrst.err_before", 32'(bus.err), 32'h1);
        @(negedge clk); rst = 1'b1; #1;
        chk("midrst.count", 32'(bus.count), 32'h0);
        chk("midrst.step",  32'(bus.step),  32'h0);
        chk("midrst.dir",   32'(bus.dir),   32'h0);
        chk("midrst.err",   32'(bus.err),   32'h0);
        @(posedge clk); #1; rst = 1'b0;
        drive_pos(1);
        for (int k = 0; k < 10; k++) tick("reinit");
        chk("reinit.count", 32'(bus.count), 32'h0);

        // Randomized walk: legal moves, illegal jumps, short holds, strobes
        for (int it = 0; it < 200; it++) begin
            int r, hold;
            r    = $urandom_range(0, 9);
            hold = $urandom_range(1, 8);
            drive_pos(pos + ((r == 0) ? 2 : (r <= 5) ? 1 : 3));
            for (int k = 0; k < hold; k++) begin
                bus.clear   = ($urandom_range(0, 15) == 0);
                bus.err_clr = ($urandom_range(0, 7) == 0);
                tick("rand");
            end
            bus.clear = 1'b0; bus.err_clr = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/quad_encoder_counter.md
Name: quad_encoder_counter

Overview:
- Consumes the synchronized A/B quadrature lines of one wheel encoder. These come from the two-flop synchronizer bank, one bit per channel.
- Per channel: glitch filter, then x4 decode into a signed wrapping position count, plus a per-step pulse/direction and a sticky illegal-transition flag.
- Sits between the input synchronizers and the motor/odometry register file.

Parameters:
- CNT_WIDTH, 16, width of the position counter, two's complement, wraps modulo 2^CNT_WIDTH.
- FILTER, 4, consecutive identical samples required before a filtered channel changes; legal range 1..255; 1 means no filtering.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enc_a  in  1  encoder channel A, already synchronized to clk
- enc_b  in  1  encoder channel B, already synchronized to clk
- clear  in  1  synchronous count clear, one-cycle pulse or level
- err_clr  in  1  synchronous clear of err
- count  out  CNT_WIDTH  signed position
- step  out  1  one-cycle pulse per decoded quadrature edge
- dir  out  1  direction of last step: 1 = forward (+1), 0 = reverse (-1)
- err  out  1  sticky: both filtered channels changed in the same cycle

Behaviour:
- Reset values (asynchronous, while rst=1): count=0, step=0, dir=0, err=0, filtered a_f=b_f=0, prev state=00, FSM=INIT, filter counters=0.

FSM, two states:
- INIT:
  - A cycle counter runs for FILTER clocks after rst deasserts.
  - On the FILTER-th clk edge: a_f<=enc_a, b_f<=enc_b, prev<={enc_a,enc_b}, go to RUN.
  - No step, no count change, no err in INIT. The power-up encoder position is therefore never counted.
- RUN: normal filtering and decode. There is no exit other than rst.

Filter (per channel, independent):
- Sample raw input every clk.
- If raw != filtered, increment that channel's counter.
- If raw == filtered, zero the counter.
- When the counter reaches FILTER-1 and raw still differs, the filtered value takes raw on that edge and the counter zeroes.
- Net effect: a raw change held for FILTER clocks reaches the filtered value on the FILTER-th edge. Shorter pulses are discarded.
- Counter width: clog2(FILTER+1).

Decode (registered, one cycle after filtered change):
- Compare cur={a_f,b_f} against prev; prev<=cur every cycle.
- Forward sequence 00->10->11->01->00: count+1, step=1, dir=1.
- Reverse sequence 00->01->11->10->00: count-1, step=1, dir=0.
- No change: step=0; count and dir hold.
- Both bits differ (00<->11, 10<->01): err<=1, step=0, count and dir hold.

Latency and arithmetic:
- Total latency from a raw input change to count/step update is FILTER+1 clocks.
- step is high exactly one cycle per legal edge.
- Count wraps: max positive +1 -> most negative; 0 -1 -> all ones. No saturation.

Priorities and simultaneous events:
- clear with a legal step in the same cycle: count<=0, while step and dir still assert for that edge. Clear wins for count.
- err_clr with a new illegal transition in the same cycle: err stays 1. Set wins.
- rst mid-operation returns to INIT immediately. Pending filter progress is lost.

Test Plan:
1. Reset release with enc_a=1, enc_b=1 held, FILTER=4 -> no step, err=0, count=0 after 10 clocks; FSM in RUN with prev=11.
2. Drive 8 forward edges (00,10,11,01,00,...), each held 6 clocks -> 8 step pulses, dir=1, count=8. Each count change occurs exactly 5 clocks after its input change.
3. From count=8, drive 3 reverse edges -> count=5, dir=0. Then a 3-clock glitch on enc_a -> no step, count stays 5.
4. CNT_WIDTH=4, count=7, one forward edge -> count=-8 (4'b1000). From 0, one reverse edge -> count=-1 (4'b1111).
5. Filtered state 00, both inputs switch to 11 on the same clock and hold -> err=1, count unchanged, step=0. err_clr asserted alone -> err=0 next cycle. err_clr coincident with another 11->00 jump -> err remains 1.
6. Assert clear on the same cycle a forward step decodes (count was 12) -> count=0, step=1, dir=1. Assert rst mid-sequence -> all outputs reset immediately, INIT re-entered.
